// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 16-bit 5-stage core (load-use, branch, jump, FP, stop).
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int REG_WIDTH    = 4,
    parameter int FP_LAT       = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] rsD,
    input  logic [REG_WIDTH-1:0] rtD,
    input  logic                 R_typeD,
    input  logic                 JumpD,
    input  logic                 StopD,
    input  logic [REG_WIDTH-1:0] rtE,
    input  logic [REG_WIDTH-1:0] rdE,
    input  logic                 RegDstE,
    input  logic                 MemReadE,
    input  logic                 RegWriteE,
    input  logic                 FloatingE,
    input  logic                 branch_takenE,
    output logic                 stall_pc,
    output logic                 stall_IF_ID,
    output logic                 flush_IF_ID,
    output logic                 stall_ID_EX,
    output logic                 flush_ID_EX,
    output logic                 bubble_EX_MEM,
    output logic                 halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, FP_BUSY, DRAIN, HALT} state_t;

    localparam logic [CNT_W-1:0] FP_INIT =
        (FP_LAT > 1) ? CNT_W'(FP_LAT - 2) : '0;
    localparam logic [CNT_W-1:0] DR_INIT = CNT_W'(DRAIN_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REG_WIDTH-1:0] destE;
    logic                 lu, fp_go;

    assign destE = RegDstE ? rdE : rtE;
    assign lu    = MemReadE & RegWriteE &
                   ((destE == rsD) | (R_typeD & (destE == rtD)));
    // Single-cycle FP ops flow through EX like any other instruction
    assign fp_go = FloatingE & (FP_LAT > 1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_pc      = 1'b0;
        stall_IF_ID   = 1'b0;
        flush_IF_ID   = 1'b0;
        stall_ID_EX   = 1'b0;
        flush_ID_EX   = 1'b0;
        bubble_EX_MEM = 1'b0;
        halted        = 1'b0;
        unique case (state_q)
            RUN: begin
                if (fp_go) begin
                    stall_pc      = 1'b1;
                    stall_IF_ID   = 1'b1;
                    stall_ID_EX   = 1'b1;
                    bubble_EX_MEM = 1'b1;
                    cnt_d         = FP_INIT;
                    state_d       = FP_BUSY;
                end else if (branch_takenE) begin
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                end else if (lu) begin
                    stall_pc    = 1'b1;
                    stall_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                end else if (StopD) begin
                    stall_pc    = 1'b1;
                    flush_IF_ID = 1'b1;
                    cnt_d       = DR_INIT;
                    state_d     = DRAIN;
                end else if (JumpD) begin
                    flush_IF_ID = 1'b1;
                end
            end
            FP_BUSY: begin
                if (cnt_q != '0) begin
                    stall_pc      = 1'b1;
                    stall_IF_ID   = 1'b1;
                    stall_ID_EX   = 1'b1;
                    bubble_EX_MEM = 1'b1;
                    cnt_d         = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                stall_pc    = 1'b1;
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                if (cnt_q == '0) state_d = HALT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HALT: begin
                stall_pc    = 1'b1;
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                halted      = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        stall_ev, flush_ev;

    assign stall_ev = stall_pc & ((state_q == RUN) | (state_q == FP_BUSY));
    assign flush_ev = (state_q == RUN) & ~fp_go & branch_takenE;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_ev && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_ev && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
